// File: rtl/rotate_pkg.sv
// Shared rotator definitions: default width/amount constants and word/amount types.
package rotate_pkg;

    localparam int ROT_WIDTH = 32;
    localparam int ROT_AMT_W = 5;

    typedef logic [ROT_WIDTH-1:0] rot_word_t;
    typedef logic [ROT_AMT_W-1:0] rot_amt_t;

endpackage : rotate_pkg

// File: rtl/rotl_stage.sv
// One registered pipeline stage of the left rotator: rotates by SHIFT when the
// matching amount bit is set, and carries the valid bit and amount along.
module rotl_stage #(
    parameter int WIDTH = 32,
    parameter int SHIFT = 1,
    parameter int AMT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AMT_W-1:0] in_amt,
    output logic             valid_q,
    output logic [WIDTH-1:0] data_q,
    output logic [AMT_W-1:0] amt_q
);

    localparam int SEL_BIT = $clog2(SHIFT);

    logic             valid_d;
    logic [WIDTH-1:0] data_d;
    logic [AMT_W-1:0] amt_d;

    // Next-state: load (and conditionally rotate) when enabled, otherwise hold.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        amt_d   = amt_q;
        if (en) begin
            valid_d = in_valid;
            amt_d   = in_amt;
            if (in_amt[SEL_BIT]) begin
                data_d = {in_data[WIDTH-SHIFT-1:0], in_data[WIDTH-1:WIDTH-SHIFT]};
            end else begin
                data_d = in_data;
            end
        end else begin
            valid_d = valid_q;
            data_d  = data_q;
            amt_d   = amt_q;
        end
    end

    // Stage register; reset clears valid and data so the output reads zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            amt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            amt_q   <= amt_d;
        end
    end

endmodule : rotl_stage

// File: rtl/rotl_pipe.sv
// Pipelined circular left rotator, one log2 rotate stage per register.
// Optional zero flag output enabled by defining ROTL_ZERO_FLAG_EN.
module rotl_pipe
    import rotate_pkg::*;
#(
    parameter int WIDTH = ROT_WIDTH,
    parameter int AMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AMT_W-1:0] in_amt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef ROTL_ZERO_FLAG_EN
    ,
    output logic             out_zero
`endif
);

    logic             vld [AMT_W+1];
    logic [WIDTH-1:0] dat [AMT_W+1];
    logic [AMT_W-1:0] amt [AMT_W+1];
    logic             adv;

    // Whole pipeline advances together; bubbles are never squeezed out.
    assign adv       = !vld[AMT_W] || out_ready;
    assign in_ready  = adv;
    assign vld[0]    = in_valid && adv;
    assign dat[0]    = in_data;
    assign amt[0]    = in_amt;
    assign out_valid = vld[AMT_W];
    assign out_data  = dat[AMT_W];

    for (genvar k = 0; k < AMT_W; k++) begin : g_stage
        rotl_stage #(
            .WIDTH (WIDTH),
            .SHIFT (1 << k),
            .AMT_W (AMT_W)
        ) u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .en       (adv),
            .in_valid (vld[k]),
            .in_data  (dat[k]),
            .in_amt   (amt[k]),
            .valid_q  (vld[k+1]),
            .data_q   (dat[k+1]),
            .amt_q    (amt[k+1])
        );
    end

`ifdef ROTL_ZERO_FLAG_EN
    logic out_zero_d;
    logic out_zero_q;

    // Rotation preserves zero-ness, so the last stage's input decides the flag.
    always_comb begin
        out_zero_d = out_zero_q;
        if (adv) begin
            out_zero_d = ~|dat[AMT_W-1];
        end else begin
            out_zero_d = out_zero_q;
        end
    end

    // Zero flag register, aligned with the last stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_zero_q <= 1'b0;
        end else begin
            out_zero_q <= out_zero_d;
        end
    end

    assign out_zero = out_zero_q;
`endif

endmodule : rotl_pipe

// File: tb/tb_rotl_pipe.sv
// Self-checking bench for rotl_pipe: directed latency/sweep/stall/reset cases
// plus randomized handshakes against a queue-based reference model.
module tb_rotl_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [4:0]  in_amt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
`ifdef ROTL_ZERO_FLAG_EN
    logic        out_zero;
`endif

    always #5 clk = ~clk;

    rotl_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef ROTL_ZERO_FLAG_EN
        ,
        .out_zero  (out_zero)
`endif
    );

    int          checks = 0;
    int          errors = 0;
    int          out_cnt = 0;
    int          in_cnt = 0;
    logic [31:0] exp_q [$];
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data = 32'd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: rotate by concatenating the word with itself.
    function automatic logic [31:0] ref_rotl(input logic [31:0] d, input logic [4:0] a);
        logic [63:0] t;
        t = {d, d} << a;
        return t[63:32];
    endfunction

    // Scoreboard and protocol monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            check("in_ready_rule", {31'd0, in_ready}, {31'd0, !out_valid || out_ready});
            if (prev_stall) begin
                check("stall_hold_data", out_data, prev_data);
                check("stall_hold_valid", {31'd0, out_valid}, 32'd1);
            end
            if (out_valid && out_ready) begin
                check("out_expected", {31'd0, exp_q.size() > 0}, 32'd1);
                if (exp_q.size() > 0) check("out_data", out_data, exp_q.pop_front());
                out_cnt++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_rotl(in_data, in_amt));
                in_cnt++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    task automatic drain(input int lim);
        int n = 0;
        out_ready = 1'b1;
        while ((exp_q.size() != 0 || out_valid) && n < lim) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_timeout", {31'd0, n < lim}, 32'd1);
    endtask

    // Present one op for a cycle (accepted since out_ready=1) and wait until it is at the output.
    task automatic send_and_wait(input logic [31:0] d, input logic [4:0] a);
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = d; in_amt = a;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        int base;
        logic acc;
        rst_n = 1'b0; in_valid = 1'b0; in_data = 32'd0; in_amt = 5'd0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_out_data", out_data, 32'd0);
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        rst_n = 1'b1;

        // Latency: accepted at edge N, visible right after edge N+4 (fifth cycle).
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = 32'h8000_0001; in_amt = 5'd1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk); #1;
            check("latency_valid", {31'd0, out_valid}, {31'd0, i == 4});
        end
        check("latency_data", out_data, 32'h0000_0003);
        drain(50);

        // Amount sweep, back to back.
        for (int a = 0; a < 32; a++) begin
            in_valid = 1'b1; in_data = 32'h1234_5678; in_amt = a[4:0];
            @(negedge clk);
            check("sweep_in_ready", {31'd0, in_ready}, 32'd1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        drain(100);

        // Fill with output stalled, hold, then release.
        out_ready = 1'b0;
        base = out_cnt;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1; in_data = $urandom; in_amt = 5'($urandom);
            @(negedge clk);
            if (!in_ready) break;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("stall_fill_count", exp_q.size(), 32'd5);
        repeat (10) @(posedge clk);
        #1;
        check("stall_in_ready", {31'd0, in_ready}, 32'd0);
        drain(50);
        check("stall_drained", out_cnt - base, 32'd5);

        // Reset with three ops in flight and one at the output.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = 32'hA5A5_0000 | i; in_amt = 5'(i + 3);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("pre_reset_valid", {31'd0, out_valid}, 32'd1);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("midreset_out_valid", {31'd0, out_valid}, 32'd0);
        check("midreset_out_data", out_data, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        base = out_cnt;
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 32'hF000_0000; in_amt = 5'd4;
        @(posedge clk); #1;
        in_valid = 1'b0;
        drain(50);
        check("post_reset_count", out_cnt - base, 32'd1);

        // Random handshakes for 2000 operations.
        base = in_cnt;
        in_valid = 1'b0;
        acc = 1'b0;
        for (int cyc = 0; cyc < 30000 && (in_cnt - base) < 2000; cyc++) begin
            out_ready = 1'($urandom);
            if (!in_valid || acc) begin
                in_valid = 1'($urandom);
                in_data  = $urandom;
                in_amt   = 5'($urandom);
            end
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("random_op_count", {31'd0, (in_cnt - base) >= 2000}, 32'd1);
        drain(100);

`ifdef ROTL_ZERO_FLAG_EN
        send_and_wait(32'h0000_0000, 5'd9);
        check("zero_flag_set", {31'd0, out_zero}, 32'd1);
        send_and_wait(32'h0000_0001, 5'd31);
        check("zero_flag_data", out_data, 32'h8000_0000);
        check("zero_flag_clear", {31'd0, out_zero}, 32'd0);
        drain(20);
`else
        send_and_wait(32'h0000_0001, 5'd31);
        check("rotr1_data", out_data, 32'h8000_0000);
        drain(20);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_rotl_pipe
